// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU: default width, opcodes and FSM states.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-operation ALU; flags are only meaningful for add/sub except zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;

    // Subtraction reuses the adder as A + ~B + 1, so carry means no-borrow.
    assign w_sub = (op == OP_SUB);
    assign w_bx  = w_sub ? ~b : b;
    assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = w_sum[WIDTH-1:0];
                carry  = w_sum[WIDTH];
                ovf    = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for alu_core: arbitration, operand capture, one-cycle
// execute stage and a result register held until the consumer accepts it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_id;

    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_carry;
    logic             r_rsp_ovf;

    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;

    // w_grant is only meaningful while w_any is high.
    always_comb begin
        w_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = RR_EN ? ~r_last : 1'b0;
        end else begin
            w_grant = ~req0_valid;
        end
    end

    assign req0_ready = (r_state == IDLE) && w_any && !w_grant;
    assign req1_ready = (r_state == IDLE) && w_any && w_grant;
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last <= w_grant;
                r_id   <= w_grant;
                r_a    <= w_grant ? req1_a  : req0_a;
                r_b    <= w_grant ? req1_b  : req0_b;
                r_op   <= w_grant ? req1_op : req0_op;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_result),
        .carry  (w_carry),
        .ovf    (w_ovf),
        .zero   (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_id     <= r_id;
            r_rsp_result <= w_result;
            r_rsp_zero   <= w_zero;
            r_rsp_carry  <= w_carry;
            r_rsp_ovf    <= w_ovf;
        end
    end

    assign rsp_valid  = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural model predicts grants and results,
// a monitor compares every presented response; a fixed-priority instance runs alongside.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_ovf, busy;
    logic [3:0] rsp_result;

    logic       f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [3:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic [2:0] f_req0_op, f_req1_op;
    logic       f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_zero, f_rsp_carry, f_rsp_ovf, f_busy;
    logic [3:0] f_rsp_result;

    alu_arbiter #(.WIDTH(4), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    alu_arbiter #(.WIDTH(4), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_op(f_req0_op),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_op(f_req1_op),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
        .rsp_zero(f_rsp_zero), .rsp_carry(f_rsp_carry), .rsp_ovf(f_rsp_ovf), .busy(f_busy)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         f_acc   = 0;
    logic [7:0] exp_q[$];

    bit m_inflight, m_last, prev_accept, prev_hs;
    int m_since;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed as {id, zero, carry, ovf, result}.
    function automatic logic [7:0] ref_rsp(input logic id, input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int ua, ub, sa, sb, s, r;
        bit c, v;
        logic [3:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin s = ua + ub;      r = s % 16; c = (s >= 16); v = (sa + sb > 7) || (sa + sb < -8); end
            3'd1: begin s = ua + 16 - ub; r = s % 16; c = (s >= 16); v = (sa - sb > 7) || (sa - sb < -8); end
            3'd2: r = 15 - ua;
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = (sa < sb) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        res = r[3:0];
        return {id, (r == 0), c, v, res};
    endfunction

    // One clock cycle: advance the model over the edge, drive new inputs, check readies.
    task automatic step(input bit v0, input bit v1, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [2:0] o0, input logic [3:0] a1, input logic [3:0] b1,
                        input logic [2:0] o1, input bit rdy);
        bit g, gv;
        @(posedge clk);
        #1;
        if (prev_hs) m_inflight = 1'b0;
        else if (m_inflight) m_since++;
        if (prev_accept) begin
            m_inflight = 1'b1;
            m_since    = 0;
        end
        chk("busy", busy, m_inflight);
        chk("rsp_valid", rsp_valid, m_inflight && m_since >= 1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
        rsp_ready  = rdy;
        #1;
        gv = !m_inflight && (v0 || v1);
        g  = (v0 && v1) ? !m_last : !v0;
        chk("req0_ready", req0_ready, gv && !g);
        chk("req1_ready", req1_ready, gv && g);
        prev_accept = gv;
        if (gv) begin
            exp_q.push_back(g ? ref_rsp(1'b1, a1, b1, o1) : ref_rsp(1'b0, a0, b0, o0));
            m_last = g;
        end
        prev_hs = m_inflight && m_since >= 1 && rdy;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0, 3'd0, 1);
    endtask

    task automatic model_reset();
        m_inflight  = 1'b0;
        m_since     = 0;
        m_last      = 1'b1;
        prev_accept = 1'b0;
        prev_hs     = 1'b0;
        exp_q.delete();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0d result=%0h expected no response", rsp_id, rsp_result);
                end else begin
                    chk("rsp", {rsp_id, rsp_zero, rsp_carry, rsp_ovf, rsp_result}, exp_q[0]);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : fixed_checker
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("fixed_req1_ready", f_req1_ready, 1'b0);
                if (f_req0_ready) f_acc++;
                if (f_rsp_valid) chk("fixed_rsp", {f_rsp_id, f_rsp_result}, {1'b0, 4'h3});
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
        f_req0_valid = 1'b1; f_req0_a = 4'h1; f_req0_b = 4'h2; f_req0_op = OP_ADD;
        f_req1_valid = 1'b1; f_req1_a = 4'h4; f_req1_b = 4'h4; f_req1_op = OP_XOR;
        f_rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", {rsp_valid, busy, rsp_id, rsp_zero, rsp_carry, rsp_ovf, rsp_result}, 10'h0);
        chk("reset_readies", {req0_ready, req1_ready}, 2'b00);
        rst_n = 1'b1;

        step(1, 0, 4'h7, 4'h9, OP_ADD, 4'h0, 4'h0, OP_ADD, 1);
        idle_steps(3);
        step(0, 1, 4'h0, 4'h0, OP_ADD, 4'h3, 4'h5, OP_SUB, 1);
        idle_steps(3);
        step(1, 0, 4'h8, 4'h1, OP_SLT, 4'h0, 4'h0, OP_ADD, 1);
        idle_steps(3);
        step(1, 0, 4'h7, 4'h1, OP_ADD, 4'h0, 4'h0, OP_ADD, 1);
        idle_steps(3);
        step(0, 1, 4'h0, 4'h0, OP_ADD, 4'h8, 4'h1, OP_SUB, 1);
        idle_steps(3);

        // Backpressure: both requesters waiting while the response is held.
        step(1, 0, 4'hA, 4'h5, OP_XOR, 4'h0, 4'h0, OP_ADD, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 4'h1, 4'h1, OP_AND, 4'h2, 4'h3, OP_OR, 0);
        step(1, 1, 4'h1, 4'h1, OP_AND, 4'h2, 4'h3, OP_OR, 1);
        step(1, 1, 4'h6, 4'h6, OP_EQ, 4'h2, 4'h3, OP_OR, 1);
        idle_steps(4);

        // Reset while the accepted operation is in the execute cycle.
        step(1, 0, 4'h5, 4'h5, OP_ADD, 4'h0, 4'h0, OP_ADD, 1);
        @(posedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_rsp_valid", rsp_valid, 1'b0);
        chk("rst_exec_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            step(1, 1, 4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                 4'($urandom), 4'($urandom), 3'($urandom),
                 4'($urandom), 4'($urandom), 3'($urandom),
                 $urandom_range(0, 99) < 70);

        idle_steps(5);
        chk("queue_drained", exp_q.size(), 0);
        chk("fixed_accepts_seen", (f_acc >= 20), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
